// File: rtl/mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one 16x16 signed multiplier among N_REQ requesters.
// Optional watchdog abort is compiled in when MULT_ARB_TIMEOUT_EN is defined.
module mult_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     rq_valid,
    output logic [N_REQ-1:0]     rq_ready,
    input  logic [16*N_REQ-1:0]  rq_arg_a,
    input  logic [16*N_REQ-1:0]  rq_arg_b,
    input  logic [N_REQ-1:0]     rq_a_par,
    input  logic [N_REQ-1:0]     rq_b_par,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [31:0]          rsp_result,
    output logic                 rsp_result_parity,
    output logic                 rsp_parity_error,
    output logic                 rsp_timeout,
    output logic                 mult_req,
    output logic [15:0]          mult_arg_a,
    output logic [15:0]          mult_arg_b,
    output logic                 mult_arg_a_parity,
    output logic                 mult_arg_b_parity,
    input  logic                 mult_ack,
    input  logic [31:0]          mult_result,
    input  logic                 mult_result_parity,
    input  logic                 mult_result_rdy,
    input  logic                 mult_arg_parity_error
);

    localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0] win_q, winner;
    logic            any_valid, xfer, capture, expire;
    logic [15:0]     sel_a, sel_b;
    logic            sel_a_par, sel_b_par;
    logic [15:0]     arg_a_q, arg_b_q;
    logic            arg_a_par_q, arg_b_par_q;
    logic [31:0]     rsp_result_q;
    logic            rsp_parity_q, rsp_perr_q;

    // Lowest valid index overall, overridden by the lowest valid index at or above rr_ptr.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (rq_valid[i]) begin
                any_valid = 1'b1;
                winner    = IdxW'(i);
            end
        end
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (rq_valid[i] && (IdxW'(i) >= rr_ptr_q)) begin
                winner = IdxW'(i);
            end
        end
    end

    always_comb begin
        sel_a     = '0;
        sel_b     = '0;
        sel_a_par = 1'b0;
        sel_b_par = 1'b0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (IdxW'(i) == winner) begin
                sel_a     = rq_arg_a[i*16 +: 16];
                sel_b     = rq_arg_b[i*16 +: 16];
                sel_a_par = rq_a_par[i];
                sel_b_par = rq_b_par[i];
            end
        end
    end

    assign xfer    = (state_q == StIdle) && any_valid;
    assign capture = ((state_q == StIssue) && mult_ack && mult_result_rdy) ||
                     ((state_q == StWait) && mult_result_rdy);

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            StIdle: begin
                if (any_valid) begin
                    state_d  = StIssue;
                    rr_ptr_d = (winner == IdxW'(N_REQ - 1)) ? '0 : winner + IdxW'(1);
                end
            end
            StIssue: begin
                if (mult_ack) state_d = mult_result_rdy ? StResp : StWait;
            end
            StWait: begin
                if (mult_result_rdy) state_d = StResp;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (expire) state_d = StResp;
    end

    always_comb begin
        rq_ready  = '0;
        rsp_valid = '0;
        if (xfer) rq_ready[winner] = 1'b1;
        if (state_q == StResp) rsp_valid[win_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            rr_ptr_q     <= '0;
            win_q        <= '0;
            arg_a_q      <= '0;
            arg_b_q      <= '0;
            arg_a_par_q  <= 1'b0;
            arg_b_par_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_parity_q <= 1'b0;
            rsp_perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            if (xfer) begin
                win_q       <= winner;
                arg_a_q     <= sel_a;
                arg_b_q     <= sel_b;
                arg_a_par_q <= sel_a_par;
                arg_b_par_q <= sel_b_par;
            end
            if (capture) begin
                rsp_result_q <= mult_result;
                rsp_parity_q <= mult_result_parity;
                rsp_perr_q   <= mult_arg_parity_error;
            end else if (expire) begin
                rsp_result_q <= '0;
                rsp_parity_q <= 1'b0;
                rsp_perr_q   <= 1'b0;
            end
        end
    end

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] cnt_q;
    logic            timeout_q;

    // Fires in the TIMEOUT-th busy cycle unless that cycle completes normally.
    assign expire = ((state_q == StIssue) || (state_q == StWait)) && !capture &&
                    (cnt_q == CntW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (xfer) begin
                cnt_q <= '0;
            end else if ((state_q == StIssue) || (state_q == StWait)) begin
                cnt_q <= cnt_q + CntW'(1);
            end
            if (capture) begin
                timeout_q <= 1'b0;
            end else if (expire) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign rsp_timeout = timeout_q;
`else
    assign expire      = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    assign mult_req          = (state_q == StIssue);
    assign mult_arg_a        = arg_a_q;
    assign mult_arg_b        = arg_b_q;
    assign mult_arg_a_parity = arg_a_par_q;
    assign mult_arg_b_parity = arg_b_par_q;
    assign rsp_result        = rsp_result_q;
    assign rsp_result_parity = rsp_parity_q;
    assign rsp_parity_error  = rsp_perr_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter: requester driver, multiplier responder and response monitor.
// Define MULT_ARB_TIMEOUT_EN to also exercise the watchdog (TIMEOUT=8).
module tb_mult_arbiter;

    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     rq_valid, rq_ready, rq_a_par, rq_b_par, rsp_valid;
    logic [16*N-1:0]  rq_arg_a, rq_arg_b;
    logic [31:0]      rsp_result, mult_result;
    logic             rsp_result_parity, rsp_parity_error, rsp_timeout;
    logic             mult_req, mult_arg_a_parity, mult_arg_b_parity;
    logic [15:0]      mult_arg_a, mult_arg_b;
    logic             mult_ack, mult_result_parity, mult_result_rdy, mult_arg_parity_error;

    always #5 clk = ~clk;

    mult_arbiter #(.N_REQ(N), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .rq_valid(rq_valid), .rq_ready(rq_ready),
        .rq_arg_a(rq_arg_a), .rq_arg_b(rq_arg_b),
        .rq_a_par(rq_a_par), .rq_b_par(rq_b_par),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result),
        .rsp_result_parity(rsp_result_parity), .rsp_parity_error(rsp_parity_error),
        .rsp_timeout(rsp_timeout),
        .mult_req(mult_req), .mult_arg_a(mult_arg_a), .mult_arg_b(mult_arg_b),
        .mult_arg_a_parity(mult_arg_a_parity), .mult_arg_b_parity(mult_arg_b_parity),
        .mult_ack(mult_ack), .mult_result(mult_result),
        .mult_result_parity(mult_result_parity), .mult_result_rdy(mult_result_rdy),
        .mult_arg_parity_error(mult_arg_parity_error)
    );

    typedef struct {
        int          idx;
        logic [15:0] a;
        logic [15:0] b;
        logic        ap;
        logic        bp;
        logic [31:0] res;
        logic        rp;
        logic        pe;
        logic        to;
        int          lat;
        int          reqc;
        int          xcyc;
    } vec_t;

    vec_t pend[$];
    vec_t sb[$];
    int   glog[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   reqc = 0;
    int   nrsp = 0;
    int   ack_dly = 0;
    int   rdy_dly = 0;
    int   t2_ord[5] = '{0, 1, 2, 3, 0};
    int   t5_ord[2] = '{0, 2};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic add(input int idx, input logic [15:0] a, input logic [15:0] b,
                       input logic ap, input logic bp, input logic [31:0] res,
                       input logic rp, input logic pe, input logic to,
                       input int lat, input int rc);
        vec_t v;
        v.idx = idx; v.a = a; v.b = b; v.ap = ap; v.bp = bp;
        v.res = res; v.rp = rp; v.pe = pe; v.to = to;
        v.lat = lat; v.reqc = rc; v.xcyc = 0;
        pend.push_back(v);
    endtask

    function automatic int find_pend(input int i);
        for (int k = 0; k < pend.size(); k++) begin
            if (pend[k].idx == i) return k;
        end
        return -1;
    endfunction

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((pend.size() != 0 || sb.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("drain_timeout", 32'(pend.size() + sb.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_reset();
        chk("rst_rq_ready", 32'(rq_ready), 32'd0);
        chk("rst_mult_req", 32'(mult_req), 32'd0);
        chk("rst_mult_arg_a", 32'(mult_arg_a), 32'd0);
        chk("rst_mult_arg_b", 32'(mult_arg_b), 32'd0);
        chk("rst_arg_par", 32'({mult_arg_a_parity, mult_arg_b_parity}), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_rsp_flags", 32'({rsp_result_parity, rsp_parity_error, rsp_timeout}), 32'd0);
    endtask

    // Requester side: transfers are decided at the negedge and take effect on the next posedge.
    initial begin : driver
        logic [N-1:0] xfer;
        int           k;
        vec_t         v;
        rq_valid = '0; rq_arg_a = '0; rq_arg_b = '0; rq_a_par = '0; rq_b_par = '0;
        forever begin
            @(negedge clk);
            if (rq_ready != '0) begin
                chk("ready_onehot", 32'($countones(rq_ready)), 32'd1);
                chk("ready_not_valid", 32'(rq_ready & ~rq_valid), 32'd0);
            end
            xfer = rq_valid & rq_ready & {N{~rst}};
            for (int i = 0; i < N; i++) begin
                if (xfer[i]) begin
                    k = find_pend(i);
                    if (k >= 0) begin
                        v = pend[k];
                        v.xcyc = cyc;
                        sb.push_back(v);
                        glog.push_back(i);
                        pend.delete(k);
                    end
                end
            end
            @(posedge clk);
            #1;
            rq_valid = '0;
            for (int i = 0; i < N; i++) begin
                k = find_pend(i);
                if (k >= 0) begin
                    rq_valid[i]          = 1'b1;
                    rq_arg_a[16*i +: 16] = pend[k].a;
                    rq_arg_b[16*i +: 16] = pend[k].b;
                    rq_a_par[i]          = pend[k].ap;
                    rq_b_par[i]          = pend[k].bp;
                end
            end
        end
    end

    // Multiplier side: ack and result_rdy come ack_dly/rdy_dly cycles after mult_req first rises.
    initial begin : responder
        int          ph;
        logic        acked, done;
        logic [31:0] sa, sb32, prod;
        ph = -1; acked = 1'b0; done = 1'b0;
        mult_ack = 1'b0; mult_result_rdy = 1'b0; mult_result = '0;
        mult_result_parity = 1'b0; mult_arg_parity_error = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ph = -1; acked = 1'b0; done = 1'b0;
            end else if (ph < 0) begin
                if (mult_req) ph = 0;
            end else if (done || (!acked && !mult_req)) begin
                ph = -1; acked = 1'b0; done = 1'b0;
            end else begin
                ph++;
            end
            sa   = {{16{mult_arg_a[15]}}, mult_arg_a};
            sb32 = {{16{mult_arg_b[15]}}, mult_arg_b};
            prod = sa * sb32;
            mult_ack = (ph >= 0) && (ph == ack_dly);
            if (mult_ack) acked = 1'b1;
            mult_result_rdy = (ph >= 0) && (ph == rdy_dly);
            if (mult_result_rdy) begin
                done                  = 1'b1;
                mult_result           = prod;
                mult_result_parity    = ^prod;
                mult_arg_parity_error = ((^mult_arg_a) != mult_arg_a_parity) ||
                                        ((^mult_arg_b) != mult_arg_b_parity);
            end else begin
                mult_result           = 32'hDEAD_BEEF;
                mult_result_parity    = 1'b1;
                mult_arg_parity_error = 1'b1;
            end
        end
    end

    initial begin : monitor
        vec_t e;
        forever begin
            @(negedge clk);
            if (rst) reqc = 0;
            else if (mult_req) reqc++;
            if (rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_valid", 32'(rsp_valid), 32'd1 << e.idx);
                    chk("rsp_result", rsp_result, e.res);
                    chk("rsp_result_parity", 32'(rsp_result_parity), 32'(e.rp));
                    chk("rsp_parity_error", 32'(rsp_parity_error), 32'(e.pe));
                    chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
                    chk("rsp_latency", 32'(cyc - e.xcyc), 32'(e.lat));
                    chk("mult_req_cycles", 32'(reqc), 32'(e.reqc));
                end
                nrsp++;
                reqc = 0;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int exp_rsp;
        int n;
        exp_rsp = 10;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset();

        // Single request: ack in cycle 2, result in cycle 5, response in cycle 6.
        ack_dly = 1; rdy_dly = 4;
        add(0, 16'h0003, 16'hFFFB, 1'b0, 1'b1, 32'hFFFF_FFF1, 1'b1, 1'b0, 1'b0, 6, 2);
        drain(100);
        do_reset();
        chk_reset();

        // All four contend: strict round-robin 0,1,2,3,0.
        ack_dly = 0; rdy_dly = 1;
        glog.delete();
        add(0, 16'h0002, 16'h0003, 1'b1, 1'b0, 32'h0000_0006, 1'b0, 1'b0, 1'b0, 3, 1);
        add(1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 3, 1);
        add(2, 16'h0064, 16'hFFFE, 1'b1, 1'b1, 32'hFFFF_FF38, 1'b1, 1'b0, 1'b0, 3, 1);
        add(3, 16'h0100, 16'h0100, 1'b1, 1'b1, 32'h0001_0000, 1'b1, 1'b0, 1'b0, 3, 1);
        add(0, 16'h8000, 16'h8000, 1'b1, 1'b1, 32'h4000_0000, 1'b1, 1'b0, 1'b0, 3, 1);
        drain(200);
        chk("t2_grant_count", 32'(glog.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk("t2_grant_order", (i < glog.size()) ? 32'(glog[i]) : 32'hFFFF_FFFF,
                32'(t2_ord[i]));
        end

        // Bad a-parity from requester 2; error flag and extreme product passed through.
        ack_dly = 2; rdy_dly = 2;
        add(2, 16'h7FFF, 16'h8000, 1'b0, 1'b1, 32'hC000_8000, 1'b1, 1'b1, 1'b0, 4, 3);
        drain(100);

        // Ack and result_rdy together in cycle 1: minimum latency.
        ack_dly = 0; rdy_dly = 0;
        add(1, 16'h0005, 16'h0007, 1'b0, 1'b1, 32'h0000_0023, 1'b1, 1'b0, 1'b0, 2, 1);
        drain(100);

        // Reset while waiting for the result: aborted, no response, pointer back to 0.
        ack_dly = 0; rdy_dly = 100;
        glog.delete();
        add(1, 16'h1234, 16'h0011, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 0);
        n = 0;
        while (glog.size() == 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        chk("t5_granted", 32'(glog.size()), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        sb.delete();
        do_reset();
        chk_reset();
        repeat (4) @(posedge clk);
        #1;
        ack_dly = 0; rdy_dly = 1;
        glog.delete();
        add(2, 16'h0003, 16'h0003, 1'b0, 1'b0, 32'h0000_0009, 1'b0, 1'b0, 1'b0, 3, 1);
        add(0, 16'h0002, 16'h0002, 1'b1, 1'b1, 32'h0000_0004, 1'b1, 1'b0, 1'b0, 3, 1);
        drain(100);
        for (int i = 0; i < 2; i++) begin
            chk("t5_grant_order", (i < glog.size()) ? 32'(glog[i]) : 32'hFFFF_FFFF,
                32'(t5_ord[i]));
        end

`ifdef MULT_ARB_TIMEOUT_EN
        // Multiplier never acks: abort after 8 request cycles, then a normal transaction.
        ack_dly = 1000; rdy_dly = 1000;
        add(3, 16'h0009, 16'h0009, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 9, 8);
        drain(100);
        ack_dly = 0; rdy_dly = 1;
        add(0, 16'h0009, 16'h0009, 1'b0, 1'b0, 32'h0000_0051, 1'b1, 1'b0, 1'b0, 3, 1);
        drain(100);
        exp_rsp = exp_rsp + 2;
`endif

        chk("rsp_count", 32'(nrsp), 32'(exp_rsp));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
